axi_burst_reader: RTL and testbench
===================================

// Module: axi_burst_reader
// PURPOSE
//  Parametrised AXI4 read master: accepts (address, beat-count) commands, splits them into INCR bursts
//  of at most MAX_BURST beats that never cross a 4 KB boundary, and keeps up to MAX_OUTSTANDING ARs in flight.
//  Returned data is buffered in an internal FIFO and emitted as a valid/ready stream with LAST on the final beat.
//  Sits between stream consumers and the DDR AXI port, as the successor to the fixed-width read stub.
// PARAMETERS
//  C_AXI_THREAD_ID_WIDTH  1    width of ARID/RID
//  C_AXI_ADDR_WIDTH       32   byte-address width
//  C_AXI_DATA_WIDTH       128  data width, power of 2, 32..512
//  LEN_WIDTH              24   width of CMD_LEN (beats)
//  MAX_BURST              16   max beats per AR, power of 2, 1..256
//  MAX_OUTSTANDING        4    max ARs issued but not completed by RLAST
//  FIFO_DEPTH             64   data FIFO entries, power of 2, >= MAX_BURST
// PORTS
//  CLK          in   1     clock
//  RST          in   1     reset
//  CMD_VALID    in   1     command valid
//  CMD_READY    out  1     command accepted when VALID&READY
//  CMD_ADDR     in   ADDR  start byte address; low log2(DATA/8) bits ignored (treated as 0)
//  CMD_LEN      in   LEN   number of beats; 0 allowed
//  CMD_DONE     out  1     1-cycle pulse when every beat of the command has been written to the FIFO
//  BUSY         out  1     state != IDLE
//  ERR          out  1     sticky: an RRESP != OKAY was seen during the current command
//  DOUT_VALID   out  1     output stream valid (FIFO not empty)
//  DOUT_READY   in   1     output stream ready
//  DOUT_DATA    out  DATA  output beat
//  DOUT_LAST    out  1     final beat of a command
//  AXI_AR*      out  --    ARID, ARADDR, ARLEN[8], ARSIZE[3], ARBURST[2], ARLOCK, ARCACHE[4], ARPROT[3], ARQOS[4], ARUSER, ARVALID
//  AXI_ARREADY  in   1     address handshake
//  AXI_R*       in   --    RID, RDATA, RRESP[2], RLAST, RUSER[DATA/8], RVALID
//  AXI_RREADY   out  1     read-data ready
// BEHAVIOUR
//  Clocking: one clock, CLK; reset RST is asynchronous, active-high.
//  Reset: state IDLE, ARVALID=0, CMD_DONE=0, ERR=0, BUSY=0, FIFO empty (DOUT_VALID=0), counters 0, CMD_READY=1.
//  Constant AR fields: ARID=0, ARSIZE=log2(DATA/8), ARBURST=2'b01, ARLOCK=0, ARCACHE=4'b0011, ARPROT=0,
//   ARQOS=0, ARUSER=0. RID and RUSER are ignored; responses are taken in order.
//  FSM:
//   IDLE:  CMD_READY=1. On accept, latch addr/len and clear ERR.
//          len==0 -> DONE; else -> CALC.
//   CALC:  burst = min(remaining, MAX_BURST, (4096-addr[11:0])/(DATA/8)).
//          Go to ISSUE once outstanding<MAX_OUTSTANDING and (FIFO free - reserved) >= burst.
//   ISSUE: ARVALID=1, ARLEN=burst-1. ARADDR/ARLEN held stable until ARREADY.
//          On handshake: addr += burst*(DATA/8), remaining -= burst, reserved += burst, outstanding++.
//          remaining!=0 -> CALC; else -> DRAIN.
//   DRAIN: wait until outstanding==0 and every beat has been written -> DONE.
//   DONE:  CMD_DONE=1 for one cycle -> IDLE.
//  R channel: AXI_RREADY = !fifo_full. The reservation scheme guarantees it never drops while a beat is due.
//   Each accepted beat is written as {last, data}; last=1 on beat number CMD_LEN of the command. reserved--.
//   RLAST&RVALID&RREADY decrements outstanding. An AR handshake and an RLAST in the same cycle leave it unchanged.
//  ERR is set on any accepted beat with RRESP!=2'b00. Data is still forwarded. ERR is cleared only on the next
//   command accept.
//  FIFO: first-word-fall-through; simultaneous push and pop on a full or empty FIFO are both legal.
//   Latency from RVALID beat to DOUT_VALID is 1 cycle.
//  Zero-length command: no AR is issued, CMD_DONE pulses 2 cycles after accept, and no DOUT beat is produced.
//  Reset mid-operation: all in-flight state is discarded. The interconnect is reset together with this block.
// TESTING
//  1 DATA=128, addr 0x1000, len 40, all ready -> ARs (0x1000,15),(0x1100,15),(0x1200,7); 40 DOUT beats in order,
//    LAST on beat 40 only, one CMD_DONE.
//  2 addr 0x0FC0, len 16 -> ARs (0x0FC0,ARLEN 3),(0x1000,ARLEN 11); no burst crosses 0x1000.
//  3 len 200, DOUT_READY=0 -> exactly 4 ARs (64 beats reserved), AXI_RREADY never low during a beat; then
//    DOUT_READY=1 -> remaining ARs issue and all 200 beats arrive with no loss or duplication.
//  4 ARREADY held low 10 cycles -> ARVALID=1 with ARADDR/ARLEN constant throughout; >MAX_OUTSTANDING never issued.
//  5 RRESP=2'b10 on beat 3 of len 8 -> ERR=1 from the next cycle, all 8 beats delivered; next accept clears ERR.
//  6 RST pulsed mid-burst (and len=0 command) -> outputs at reset values within the reset cycle;
//    len=0 gives CMD_DONE with no AR.

Source files
------------

// File: rtl/axi_burst_reader_if.sv
// AXI4 read-address and read-data channels shared by the burst reader and its slave.
interface axi_burst_reader_if #(
  parameter int unsigned ID_W     = 1,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned ARUSER_W = 1
) ();
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic [ARUSER_W-1:0] aruser;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic [DATA_W/8-1:0] ruser;
  logic                rvalid;
  logic                rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_burst_reader.sv
// AXI4 read master: splits (addr, beats) commands into 4 KB-safe INCR bursts and
// streams the returned data out of a first-word-fall-through FIFO.
module axi_burst_reader #(
  parameter int unsigned C_AXI_THREAD_ID_WIDTH = 1,
  parameter int unsigned C_AXI_ADDR_WIDTH      = 32,
  parameter int unsigned C_AXI_DATA_WIDTH      = 128,
  parameter int unsigned LEN_WIDTH             = 24,
  parameter int unsigned MAX_BURST             = 16,
  parameter int unsigned MAX_OUTSTANDING       = 4,
  parameter int unsigned FIFO_DEPTH            = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [C_AXI_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]        cmd_len_i,
  output logic                        cmd_done_o,
  output logic                        busy_o,
  output logic                        err_o,
  output logic                        dout_valid_o,
  input  logic                        dout_ready_i,
  output logic [C_AXI_DATA_WIDTH-1:0] dout_data_o,
  output logic                        dout_last_o,
  axi_burst_reader_if.master          axi
);

  localparam int unsigned AW         = C_AXI_ADDR_WIDTH;
  localparam int unsigned DW         = C_AXI_DATA_WIDTH;
  localparam int unsigned LW         = LEN_WIDTH;
  localparam int unsigned SIZE       = $clog2(DW / 8);
  localparam int unsigned PAGE_BEATS = 4096 / (DW / 8);
  localparam int unsigned BW         = $clog2(MAX_BURST + 1);
  localparam int unsigned OW         = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW         = CW + 2;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   beats_q, beats_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [CW-1:0]   resv_q, resv_d;
  logic [OW-1:0]   outs_q, outs_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [DW:0]     mem_q [FIFO_DEPTH];

  logic            ar_hs_c, r_hs_c, pop_c, acc_c, full_c, last_c, fits_c;
  logic [12:0]     page_left_c;
  logic [BW-1:0]   burst_c;
  logic            unused_c;

  assign unused_c = ^{axi.rid, axi.ruser, cmd_addr_i[SIZE-1:0]};

  assign ar_hs_c = axi.arvalid & axi.arready;
  assign r_hs_c  = axi.rvalid & axi.rready;
  assign pop_c   = dout_valid_o & dout_ready_i;
  assign acc_c   = (state_q == S_IDLE) & cmd_valid_i;
  assign full_c  = (cnt_q == CW'(FIFO_DEPTH));
  assign last_c  = ((beats_q + LW'(1)) == len_q);

  // Next burst: limited by beats left, MAX_BURST and the distance to the next 4 KB page.
  always_comb begin
    page_left_c = 13'(PAGE_BEATS) - 13'(addr_q[11:SIZE]);
    burst_c     = BW'(MAX_BURST);
    if (page_left_c < 13'(MAX_BURST)) burst_c = BW'(page_left_c);
    if (rem_q < LW'(burst_c))         burst_c = BW'(rem_q);
    fits_c = (SW'(cnt_q) + SW'(resv_q) + SW'(burst_c)) <= SW'(FIFO_DEPTH);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    len_d   = len_q;
    burst_d = burst_q;
    err_d   = err_q;
    done_d  = (state_q == S_DONE);

    if (r_hs_c && (axi.rresp != 2'b00)) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          addr_d  = {cmd_addr_i[AW-1:SIZE], SIZE'(0)};
          rem_d   = cmd_len_i;
          len_d   = cmd_len_i;
          err_d   = 1'b0;
          state_d = (cmd_len_i == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if ((outs_q < OW'(MAX_OUTSTANDING)) && fits_c) begin
          burst_d = burst_c;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (axi.arready) begin
          addr_d  = addr_q + (AW'(burst_q) << SIZE);
          rem_d   = rem_q - LW'(burst_q);
          state_d = (rem_q == LW'(burst_q)) ? S_DRAIN : S_CALC;
        end
      end
      S_DRAIN: begin
        if ((outs_q == '0) && (beats_q == len_q)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Beat, reservation and outstanding-AR bookkeeping.
  always_comb begin
    beats_d = beats_q;
    if (acc_c)       beats_d = '0;
    else if (r_hs_c) beats_d = beats_q + LW'(1);

    resv_d = resv_q;
    if (ar_hs_c) resv_d = resv_d + CW'(burst_q);
    if (r_hs_c)  resv_d = resv_d - CW'(1);

    outs_d = outs_q;
    if (ar_hs_c)            outs_d = outs_d + OW'(1);
    if (r_hs_c & axi.rlast) outs_d = outs_d - OW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      len_q    <= '0;
      beats_q  <= '0;
      burst_q  <= '0;
      resv_q   <= '0;
      outs_q   <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      len_q    <= len_d;
      beats_q  <= beats_d;
      burst_q  <= burst_d;
      resv_q   <= resv_d;
      outs_q   <= outs_d;
      err_q    <= err_d;
      done_q   <= done_d;
      if (r_hs_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q    <= cnt_q + CW'(r_hs_c) - CW'(pop_c);
    end
  end

  // FIFO storage holds {last, data}; no reset needed since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (r_hs_c) mem_q[wr_ptr_q] <= {last_c, axi.rdata};
  end

  assign {dout_last_o, dout_data_o} = mem_q[rd_ptr_q];
  assign dout_valid_o = (cnt_q != '0);
  assign cmd_ready_o  = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign cmd_done_o   = done_q;
  assign err_o        = err_q;

  assign axi.rready   = ~full_c;
  assign axi.arvalid  = (state_q == S_ISSUE);
  assign axi.araddr   = addr_q;
  assign axi.arlen    = 8'(burst_q - BW'(1));
  assign axi.arid     = '0;
  assign axi.arsize   = 3'(SIZE);
  assign axi.arburst  = 2'b01;
  assign axi.arlock   = 1'b0;
  assign axi.arcache  = 4'b0011;
  assign axi.arprot   = 3'b000;
  assign axi.arqos    = 4'b0000;
  assign axi.aruser   = '0;

endmodule

// File: tb/tb_axi_burst_reader.sv
// Scoreboard bench for axi_burst_reader: memory-slave model, AR/DOUT/DONE/ERR checking.
module tb_axi_burst_reader;
  localparam int unsigned DW    = 128;
  localparam int unsigned BYTES = DW / 8;
  localparam int unsigned MAXB  = 16;
  localparam int unsigned MAXO  = 4;
  localparam int unsigned DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_done, busy, err;
  logic [31:0]   cmd_addr;
  logic [23:0]   cmd_len;
  logic          dout_valid, dout_ready, dout_last;
  logic [DW-1:0] dout_data;

  axi_burst_reader_if #(.ID_W(1), .ADDR_W(32), .DATA_W(DW)) axi ();

  axi_burst_reader #(
    .C_AXI_THREAD_ID_WIDTH(1), .C_AXI_ADDR_WIDTH(32), .C_AXI_DATA_WIDTH(DW), .LEN_WIDTH(24),
    .MAX_BURST(MAXB), .MAX_OUTSTANDING(MAXO), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
    .cmd_done_o(cmd_done), .busy_o(busy), .err_o(err),
    .dout_valid_o(dout_valid), .dout_ready_i(dout_ready), .dout_data_o(dout_data), .dout_last_o(dout_last),
    .axi(axi)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [7:0] len; } ar_t;
  typedef struct { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct { logic [DW-1:0] data; logic last; logic [1:0] resp; } rbeat_t;

  ar_t    exp_ar[$];
  beat_t  exp_dout[$];
  rbeat_t r_q[$];

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          out_tb = 0, ar_cnt = 0, stall_seen = 0, ar_stall = 0, dr_mode = 0;
  int          done_seen = 0, done_exp = 0, last_done_cyc = -1, acc_cyc = 0;
  logic [31:0] salt = 32'h0, err_addr = 32'hFFFF_FFFF;
  logic        rnd = 1'b0, err_exp = 1'b0;
  logic        prev_pend = 1'b0, r_hs = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [7:0]  prev_len = 8'h0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input logic [31:0] a, input logic [31:0] s);
    return {a ^ s, ~a, s, a};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory slave + monitors: observe at negedge (values seen by the next posedge), drive after posedge.
  initial begin : bus
    logic   ar_hs, d_hs;
    ar_t    a;
    beat_t  b;
    rbeat_t rb;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_ar.delete(); exp_dout.delete(); r_q.delete();
        out_tb = 0; err_exp = 1'b0; prev_pend = 1'b0; r_hs = 1'b0;
      end else begin
        ar_hs = axi.arvalid && axi.arready;
        r_hs  = axi.rvalid && axi.rready;
        d_hs  = dout_valid && dout_ready;
        check("err_flag", err, err_exp);
        if (axi.rvalid) check("rready_during_beat", axi.rready, 1);
        if (prev_pend) check("ar_hold", {axi.arvalid, axi.araddr, axi.arlen}, {1'b1, prev_addr, prev_len});
        if (axi.arvalid && !axi.arready) stall_seen++;
        prev_pend = axi.arvalid && !axi.arready;
        prev_addr = axi.araddr;
        prev_len  = axi.arlen;
        if (ar_hs) begin
          ar_cnt++;
          check("ar_outstanding_limit", out_tb < MAXO, 1);
          check("ar_const", {axi.arid, axi.arsize, axi.arburst, axi.arlock, axi.arcache, axi.arprot, axi.arqos, axi.aruser},
                {1'b0, 3'd4, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000, 1'b0});
          check("ar_expected", exp_ar.size() != 0, 1);
          if (exp_ar.size() != 0) begin
            a = exp_ar.pop_front();
            check("ar_addr_len", {axi.araddr, axi.arlen}, {a.addr, a.len});
          end
          for (int i = 0; i <= int'(axi.arlen); i++) begin
            rb.data = pat(axi.araddr + 32'(i * BYTES), salt);
            rb.last = (i == int'(axi.arlen));
            rb.resp = ((axi.araddr + 32'(i * BYTES)) == err_addr) ? 2'b10 : 2'b00;
            r_q.push_back(rb);
          end
          out_tb++;
        end
        if (r_hs) begin
          void'(r_q.pop_front());
          if (axi.rlast) out_tb--;
        end
        if (d_hs) begin
          check("dout_expected", exp_dout.size() != 0, 1);
          if (exp_dout.size() != 0) begin
            b = exp_dout.pop_front();
            check("dout_beat", {dout_last, dout_data}, {b.last, b.data});
          end
        end
        if (cmd_done) begin
          check("done_expected", done_seen < done_exp, 1);
          check("done_after_all_beats", {r_q.size() == 0, out_tb == 0, exp_ar.size() == 0}, 3'b111);
          done_seen++;
          last_done_cyc = cyc;
        end
        if (cmd_valid && cmd_ready) err_exp = 1'b0;
        else if (r_hs && axi.rresp != 2'b00) err_exp = 1'b1;
      end
      @(posedge clk);
      #1;
      if (rst) begin
        axi.rvalid  = 1'b0;
        axi.arready = 1'b0;
      end else begin
        if (ar_stall > 0) begin
          axi.arready = 1'b0;
          ar_stall--;
        end else begin
          axi.arready = !rnd || ($urandom % 3 != 0);
        end
        if (r_q.size() != 0 && ((axi.rvalid && !r_hs) || !rnd || ($urandom % 3 != 0))) begin
          axi.rvalid = 1'b1;
          axi.rdata  = r_q[0].data;
          axi.rlast  = r_q[0].last;
          axi.rresp  = r_q[0].resp;
        end else begin
          axi.rvalid = 1'b0;
        end
        axi.rid    = 1'($urandom);
        dout_ready = (dr_mode == 1) || (dr_mode == 2 && ($urandom % 2 == 0));
      end
    end
  end

  // Reference split: bursts of <= MAXB beats that never cross a 4 KB page; data follows the beat address.
  task automatic issue(input logic [31:0] a, input int unsigned n);
    logic [31:0]  ba;
    int unsigned  rem, b, page;
    int           t;
    ar_t          e;
    beat_t        d;
    salt   = $urandom;
    ar_cnt = 0;
    ba     = a & ~32'hF;
    rem    = n;
    while (rem > 0) begin
      page = (4096 - int'(ba[11:0])) / BYTES;
      b = rem;
      if (b > MAXB) b = MAXB;
      if (b > page) b = page;
      e.addr = ba;
      e.len  = 8'(b - 1);
      exp_ar.push_back(e);
      ba  = ba + 32'(b * BYTES);
      rem = rem - b;
    end
    for (int i = 0; i < int'(n); i++) begin
      d.data = pat((a & ~32'hF) + 32'(i * BYTES), salt);
      d.last = (i == int'(n) - 1);
      exp_dout.push_back(d);
    end
    done_exp++;
    @(posedge clk);
    #2;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = 24'(n);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!cmd_ready && t < 1000);
    check("cmd_accept", cmd_ready, 1);
    acc_cyc = cyc;
    @(posedge clk);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (done_seen < done_exp && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("done_arrived", done_seen >= done_exp, 1);
    if (done_seen < done_exp) done_exp = done_seen;
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while (exp_dout.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("drain_complete", {exp_dout.size() == 0, dout_valid}, 2'b10);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] a;
    int unsigned n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; dout_ready = 1'b0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
    axi.rlast = 1'b0; axi.rid = '0; axi.ruser = '0;
    repeat (3) @(posedge clk);
    #3;
    check("reset_outputs", {cmd_ready, busy, cmd_done, err, dout_valid, axi.arvalid, axi.rready}, 7'b1000001);
    @(posedge clk);
    #2;
    rst = 1'b0;
    dr_mode = 1;

    // Page-aligned 40-beat read.
    issue(32'h0000_1000, 40);
    wait_done(2000);
    check("t1_ar_count", ar_cnt, 3);
    wait_drain(500);

    // Start 4 beats before a page boundary.
    issue(32'h0000_0FC0, 16);
    wait_done(2000);
    check("t2_ar_count", ar_cnt, 2);
    wait_drain(500);

    // Back-pressure: FIFO fills, issuing stops at the reservation limit.
    dr_mode = 0;
    issue(32'h0000_2000, 200);
    repeat (300) @(negedge clk);
    check("t3_ar_count_stalled", ar_cnt, 4);
    check("t3_full_busy", {dout_valid, busy, cmd_done}, 3'b110);
    dr_mode = 1;
    wait_done(5000);
    check("t3_ar_count_total", ar_cnt, 13);
    wait_drain(500);

    // ARREADY held low: ARVALID/ARADDR/ARLEN must hold.
    issue(32'h0000_3000, 40);
    stall_seen = 0;
    ar_stall = 12;
    wait_done(2000);
    check("t4_stall_observed", stall_seen >= 10, 1);
    wait_drain(500);

    // Error response on beat 3; ERR sticks until the next accept.
    err_addr = 32'h0000_4020;
    issue(32'h0000_4000, 8);
    wait_done(2000);
    wait_drain(500);
    check("t5_err_sticky", err, 1);
    err_addr = 32'hFFFF_FFFF;
    issue(32'h0000_500F, 5);
    check("t5_err_cleared", err, 0);
    wait_done(2000);
    wait_drain(500);

    // Reset mid-burst, then a zero-length command.
    rnd = 1'b1;
    dr_mode = 2;
    issue(32'h0000_6000, 100);
    repeat (40) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_reset_outputs", {cmd_ready, busy, cmd_done, err, dout_valid, axi.arvalid, axi.rready}, 7'b1000001);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    done_exp = done_seen;
    rnd = 1'b0;
    dr_mode = 1;
    issue(32'h0000_7000, 0);
    wait_done(100);
    check("t6_len0_done_timing", last_done_cyc, acc_cyc + 2);
    check("t6_len0_no_ar", ar_cnt, 0);
    repeat (5) @(negedge clk);
    check("t6_len0_no_dout", dout_valid, 0);

    // Randomised commands around page boundaries with random handshakes and error beats.
    rnd = 1'b1;
    dr_mode = 2;
    for (int k = 0; k < 10; k++) begin
      a = 32'($urandom_range(1, 4)) * 32'd4096 - 32'(16 * $urandom_range(0, 20)) + 32'($urandom_range(0, 15));
      n = $urandom_range(0, 70);
      err_addr = ($urandom % 2 == 0) ? ((a & ~32'hF) + 32'(16 * $urandom_range(0, 70))) : 32'hFFFF_FFFF;
      issue(a, n);
      wait_done(4000);
    end
    dr_mode = 1;
    wait_drain(1000);
    check("final_queues_empty", {exp_ar.size() == 0, r_q.size() == 0, out_tb == 0}, 3'b111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
